// File: rtl/npu_conv_sched_if.sv
// Scheduler-to-datapath bundle: image SRAM read port, PE/weight strobes and the
// result valid/ready handshake towards the packer.
interface npu_conv_sched_if #(
  parameter int ADDR_W = 8,
  parameter int K_H    = 3,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4
);
  logic                mem_re;
  logic [ADDR_W-1:0]   mem_addr;
  logic [8*K_H-1:0]    mem_rdata;
  logic                col_load;
  logic [8*K_H-1:0]    col_data;
  logic                pe_clear;
  logic                pe_en;
  logic                w_shift;
  logic signed [23:0]  pe_sum;
  logic                res_valid;
  logic                res_ready;
  logic [23:0]         res_data;
  logic [ROW_W-1:0]    out_row;
  logic [COL_W-1:0]    out_col;

  modport master (
    output mem_re, mem_addr, col_load, col_data, pe_clear, pe_en, w_shift,
    output res_valid, res_data, out_row, out_col,
    input  mem_rdata, pe_sum, res_ready
  );

  modport slave (
    input  mem_re, mem_addr, col_load, col_data, pe_clear, pe_en, w_shift,
    input  res_valid, res_data, out_row, out_col,
    output mem_rdata, pe_sum, res_ready
  );
endinterface

// File: rtl/npu_conv_sched.sv
// Walks a K_H x K_W valid convolution over the image, sequencing SRAM column fetches,
// PE clear/MAC/weight-shift strobes and result hand-off. NPU_SCHED_PERF_EN adds perf counters.
module npu_conv_sched #(
  parameter int IMG_H  = 16,
  parameter int IMG_W  = 15,
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             relu_en,
  output logic             busy,
  output logic             done,
  output logic [31:0]      perf_cyc,
  output logic [31:0]      perf_stall,
  npu_conv_sched_if.master bus
);
  localparam int OUT_H = IMG_H - K_H + 1;
  localparam int OUT_W = IMG_W - K_W + 1;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int CNT_W = $clog2(K_W + 1);

  typedef enum logic [2:0] {IDLE, FILL, CLR, MAC, WAIT, EMIT, SLIDE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic [COL_W-1:0]   col_reg, col_next;
  logic               relu_reg;
  logic [23:0]        res_data_reg;
  logic [8*K_H-1:0]   col_hold_reg;
  logic [ADDR_W-1:0]  row_base;

  logic               mem_re, col_load, pe_clear, pe_en, res_valid, done_s;
  logic [ADDR_W-1:0]  mem_addr;

  assign row_base = ADDR_W'(int'(row_reg) * IMG_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      relu_reg     <= 1'b0;
      res_data_reg <= '0;
      col_hold_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      if (state_reg == IDLE && start && !abort)
        relu_reg <= relu_en;
      if (state_reg == WAIT && state_next == EMIT)
        res_data_reg <= (relu_reg && bus.pe_sum[23]) ? 24'd0 : bus.pe_sum;
      if (col_load)
        col_hold_reg <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    mem_re     = 1'b0;
    mem_addr   = '0;
    col_load   = 1'b0;
    pe_clear   = 1'b0;
    pe_en      = 1'b0;
    res_valid  = 1'b0;
    done_s     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          cnt_next   = '0;
          row_next   = '0;
          col_next   = '0;
        end
      end
      FILL: begin
        // Read k and load k-1 share a cycle; the final cycle only loads.
        mem_re   = (cnt_reg < CNT_W'(K_W));
        mem_addr = mem_re ? row_base + ADDR_W'(cnt_reg) : '0;
        col_load = (cnt_reg != '0);
        if (cnt_reg == CNT_W'(K_W)) begin
          state_next = CLR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CLR: begin
        pe_clear   = 1'b1;
        state_next = MAC;
        cnt_next   = '0;
      end
      MAC: begin
        pe_en = 1'b1;
        if (cnt_reg == CNT_W'(K_W - 1)) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT: state_next = EMIT;
      EMIT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          cnt_next = '0;
          if (col_reg < COL_W'(OUT_W - 1)) begin
            col_next   = col_reg + 1'b1;
            state_next = SLIDE;
          end else if (row_reg < ROW_W'(OUT_H - 1)) begin
            row_next   = row_reg + 1'b1;
            col_next   = '0;
            state_next = FILL;
          end else begin
            state_next = DONE;
          end
        end
      end
      SLIDE: begin
        if (cnt_reg == '0) begin
          mem_re   = 1'b1;
          mem_addr = row_base + ADDR_W'(int'(col_reg) + K_W - 1);
          cnt_next = 1'b1;
        end else begin
          col_load   = 1'b1;
          state_next = CLR;
          cnt_next   = '0;
        end
      end
      DONE: begin
        done_s     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Cancel silences everything in the abort cycle itself, including a pending result.
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      row_next   = row_reg;
      col_next   = col_reg;
      mem_re     = 1'b0;
      mem_addr   = '0;
      col_load   = 1'b0;
      pe_clear   = 1'b0;
      pe_en      = 1'b0;
      res_valid  = 1'b0;
      done_s     = 1'b0;
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = done_s;
  assign bus.mem_re    = mem_re;
  assign bus.mem_addr  = mem_addr;
  assign bus.col_load  = col_load;
  // The SRAM word arrives in the load cycle, so it is forwarded then and held afterwards.
  assign bus.col_data  = col_load ? bus.mem_rdata : col_hold_reg;
  assign bus.pe_clear  = pe_clear;
  assign bus.pe_en     = pe_en;
  assign bus.w_shift   = pe_en;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_reg;
  assign bus.out_row   = row_reg;
  assign bus.out_col   = col_reg;

`ifdef NPU_SCHED_PERF_EN
  logic [31:0] perf_cyc_reg, perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cyc_reg   <= '0;
      perf_stall_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        perf_cyc_reg   <= '0;
        perf_stall_reg <= '0;
      end
    end else begin
      if (perf_cyc_reg != 32'hFFFF_FFFF)
        perf_cyc_reg <= perf_cyc_reg + 1'b1;
      if (state_reg == EMIT && !bus.res_ready && perf_stall_reg != 32'hFFFF_FFFF)
        perf_stall_reg <= perf_stall_reg + 1'b1;
    end
  end

  assign perf_cyc   = perf_cyc_reg;
  assign perf_stall = perf_stall_reg;
`else
  assign perf_cyc   = 32'd0;
  assign perf_stall = 32'd0;
`endif
endmodule

// File: tb/tb_npu_conv_sched.sv
// Bench for npu_conv_sched: SRAM + PE datapath model, scoreboard of expected conv results.
module tb_npu_conv_sched;
  localparam int IMG_H = 16, IMG_W = 15, K_H = 3, K_W = 3, ADDR_W = 8;
  localparam int OUT_H = IMG_H - K_H + 1, OUT_W = IMG_W - K_W + 1;
  localparam int NRES = OUT_H * OUT_W;

  logic clk, rst, start, abort, relu_en, busy, done, w_load;
  logic [31:0] perf_cyc, perf_stall;

  npu_conv_sched_if #(.ADDR_W(ADDR_W), .K_H(K_H), .ROW_W(4), .COL_W(4)) bus ();

  npu_conv_sched #(.IMG_H(IMG_H), .IMG_W(IMG_W), .K_H(K_H), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .relu_en(relu_en),
    .busy(busy), .done(done), .perf_cyc(perf_cyc), .perf_stall(perf_stall), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        img     [IMG_H][IMG_W];
  logic signed [7:0] wt      [K_H][K_W];
  logic [7:0]        img_reg [K_H][K_W];
  logic signed [7:0] w_reg   [K_H][K_W];
  int                pe_acc, mac_idx;
  logic [8*K_H-1:0]  rdata;

  typedef struct { int r; int c; logic [23:0] d; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  function automatic logic [8*K_H-1:0] col_word(input logic [ADDR_W-1:0] a);
    logic [8*K_H-1:0] w;
    int r, c;
    r = int'(a) / IMG_W;
    c = int'(a) % IMG_W;
    w = '0;
    for (int i = 0; i < K_H; i++)
      if (r + i < IMG_H) w[8*i +: 8] = img[r+i][c];
    return w;
  endfunction

  function automatic int mac_term(input int m);
    int s;
    s = 0;
    if (m < K_W)
      for (int i = 0; i < K_H; i++) s += int'(img_reg[i][m]) * int'(w_reg[i][0]);
    return s;
  endfunction

  function automatic int conv_at(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++) s += int'(img[r+i][c+j]) * int'(wt[i][j]);
    return s;
  endfunction

  // Datapath model: 1-cycle SRAM, column shift register, rotating weights, registered PE sum.
  always @(posedge clk) begin
    if (bus.mem_re) rdata <= col_word(bus.mem_addr);
    if (bus.col_load)
      for (int i = 0; i < K_H; i++) begin
        for (int j = 0; j < K_W - 1; j++) img_reg[i][j] <= img_reg[i][j+1];
        img_reg[i][K_W-1] <= bus.col_data[8*i +: 8];
      end
    if (bus.pe_clear) begin
      pe_acc  <= 0;
      mac_idx <= 0;
    end else if (bus.pe_en) begin
      pe_acc  <= pe_acc + mac_term(mac_idx);
      mac_idx <= mac_idx + 1;
    end
    if (w_load) begin
      for (int i = 0; i < K_H; i++)
        for (int j = 0; j < K_W; j++) w_reg[i][j] <= wt[i][j];
    end else if (bus.w_shift) begin
      for (int i = 0; i < K_H; i++)
        for (int j = 0; j < K_W; j++) w_reg[i][j] <= w_reg[i][(j+1)%K_W];
    end
  end

  assign bus.mem_rdata = rdata;
  assign bus.pe_sum    = pe_acc[23:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h (%0d) expected %0h (%0d)", tag, got, got, expv, expv);
    end
  endtask

  task automatic load_weights();
    @(negedge clk); w_load = 1'b1;
    @(negedge clk); w_load = 1'b0;
  endtask

  task automatic build_expect(input bit relu);
    exp_t e;
    int v;
    exp_q.delete();
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) begin
        v   = conv_at(r, c);
        e.r = r;
        e.c = c;
        e.d = (relu && v < 0) ? 24'd0 : v[23:0];
        exp_q.push_back(e);
      end
  endtask

  // mode: 0 plain, 1 stall 2nd result 7 cycles, 2 start while busy, 3 abort in SLIDE row 2, 4 rst mid-MAC row 3
  task automatic run_pass(input bit relu, input int mode, input int exp_done);
    int cyc, nres, done_cnt, done_at, viol, s, stall_n, stall_bad, naddr, quiet;
    bit hit;
    logic [23:0] hold;
    logic [ADDR_W-1:0] addrs [IMG_W];
    exp_t e;
    cyc = 0; nres = 0; done_cnt = 0; done_at = -1; viol = 0; stall_n = 0;
    stall_bad = 0; naddr = 0; hit = 1'b0; hold = '0;
    load_weights();
    build_expect(relu);
    @(negedge clk);
    relu_en = relu;
    start   = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (mode == 2 && (cyc == 50 || cyc == 700));
      s = int'(bus.mem_re) + int'(bus.col_load) + int'(bus.pe_clear) + int'(bus.pe_en);
      if (s > 1 && !(s == 2 && bus.mem_re && bus.col_load)) viol++;
      if (bus.w_shift !== bus.pe_en) viol++;
      if (bus.mem_re && bus.out_row == 0 && naddr < IMG_W) begin
        addrs[naddr] = bus.mem_addr;
        naddr++;
      end
      if (mode == 3 && bus.mem_re && bus.out_row == 2 && bus.out_col == 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", bus.res_valid, 0);
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
          if (bus.mem_re || done || busy) quiet++;
          @(negedge clk);
        end
        chk("abort_quiet", quiet, 0);
        chk("abort_no_done", done_cnt, 0);
        hit = 1'b1;
        break;
      end
      if (mode == 4 && bus.pe_en && bus.out_row == 3) begin
        rst = 1'b1;
        #1;
        chk("rst_strobes", {busy, done, bus.mem_re, bus.col_load, bus.pe_clear,
                            bus.pe_en, bus.w_shift, bus.res_valid}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_col_data", bus.col_data, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_out_pos", {bus.out_row, bus.out_col}, 0);
        @(negedge clk);
        rst = 1'b0;
        hit = 1'b1;
        break;
      end
      bus.res_ready = 1'b1;
      if (mode == 1 && nres == 1 && stall_n > 0 && stall_n < 7 && !bus.res_valid) stall_bad++;
      if (mode == 1 && bus.res_valid && nres == 1 && stall_n < 7) begin
        bus.res_ready = 1'b0;
        if (stall_n == 0) hold = bus.res_data;
        else if (bus.res_data !== hold) stall_bad++;
        stall_n++;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_data", bus.res_data, e.d);
          chk("res_row", bus.out_row, e.r);
          chk("res_col", bus.out_col, e.c);
        end
        $display("res %0d row=%0d col=%0d data=%06h", nres, bus.out_row, bus.out_col, bus.res_data);
        nres++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (done_at > 0 && cyc == done_at + 3) break;
    end
    bus.res_ready = 1'b1;
    if (mode >= 3) begin
      chk("event_reached", hit, 1);
    end else begin
      chk("result_count", nres, NRES);
      chk("done_pulses", done_cnt, 1);
      chk("done_cycle", done_at, exp_done);
      chk("strobe_rules", viol, 0);
      chk("idle_after", busy, 0);
      if (mode == 0) begin
        chk("row0_reads", naddr, IMG_W);
        for (int k = 0; k < IMG_W; k++) chk("row0_addr", addrs[k], k);
      end
      if (mode == 1) begin
        chk("stall_cycles", stall_n, 7);
        chk("stall_stable", stall_bad, 0);
`ifdef NPU_SCHED_PERF_EN
        chk("perf_stall", perf_stall, 7);
        chk("perf_cyc", perf_cyc, exp_done);
`else
        chk("perf_stall_tied", perf_stall, 0);
        chk("perf_cyc_tied", perf_cyc, 0);
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; relu_en = 1'b0; w_load = 1'b0;
    bus.res_ready = 1'b1;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = 8'd1;
    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++) wt[i][j] = 8'sd1;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {busy, done, bus.mem_re, bus.col_load, bus.pe_clear,
                          bus.pe_en, bus.w_shift, bus.res_valid}, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_col_data", bus.col_data, 0);
    chk("reset_res_data", bus.res_data, 0);
    chk("reset_out_pos", {bus.out_row, bus.out_col}, 0);
    chk("reset_perf", perf_cyc | perf_stall, 0);
    rst = 1'b0;

    run_pass(1'b0, 0, 1485);

    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++) wt[i][j] = 8'sd0;
    wt[0][0] = -8'sd5;
    run_pass(1'b1, 0, 1485);
    run_pass(1'b0, 0, 1485);

    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = 8'($urandom_range(0, 255));
    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++) wt[i][j] = 8'($urandom_range(0, 255));
    run_pass(1'b1, 1, 1492);
    run_pass(1'b0, 2, 1485);
    run_pass(1'b0, 3, 0);
    run_pass(1'b1, 4, 0);
    run_pass(1'b1, 0, 1485);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_conv_sched.md
# npu_conv_sched

Autonomous convolution scheduler for the NPU conv datapath: the 3-row circular image register, the rotating weight register and the K_H PE array. The host currently steps each window by hand. This block instead walks a K_H×K_W valid convolution over an IMG_H×IMG_W image and does the following:
- fetches packed image columns from a 1-cycle-latency SRAM;
- sequences the column-load, PE clear, MAC and weight-shift strobes;
- applies optional ReLU;
- hands each output to a downstream packer over a valid/ready port.

## Interface
Parameters:
- IMG_H, 16, image rows
- IMG_W, 15, image columns
- K_H, 3, kernel rows; equals the PE count
- K_W, 3, kernel columns; equals the MAC cycles per output
- ADDR_W, 8, image SRAM address width; must hold (IMG_H-K_H+1)*IMG_W-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  synchronous cancel; takes priority over everything except rst
- relu_en  in  1  latched at start; 1 clamps negative results to 0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- mem_re  out  1  image SRAM read strobe
- mem_addr  out  ADDR_W  read address = row*IMG_W + col
- mem_rdata  in  8*K_H  packed column (byte i = pixel row+i), valid the cycle after mem_re
- col_load  out  1  load mem_rdata into the image register (shift in newest column)
- col_data  out  8*K_H  registered copy of mem_rdata, valid with col_load
- pe_clear  out  1  clear PE accumulators
- pe_en  out  1  PE accumulate enable
- w_shift  out  1  rotate weight register one column
- pe_sum  in  24  signed PE adder tree output (registered in datapath, 1-cycle latency)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  24  signed result
- out_row  out  $clog2(IMG_H)  current output row
- out_col  out  $clog2(IMG_W)  current output column

## Operation
- OUT_H = IMG_H-K_H+1 (14) and OUT_W = IMG_W-K_W+1 (13).
- States and transitions:
  - IDLE -> FILL on start.
  - FILL: issue K_W reads at row*IMG_W+0..K_W-1 on consecutive cycles. col_load follows each read by 1 cycle. Lasts K_W+1 cycles, then CLR.
  - CLR: pe_clear for 1 cycle, then MAC.
  - MAC: pe_en=w_shift=1 for exactly K_W cycles. The weight register returns to its original phase afterwards. Then WAIT.
  - WAIT: 1 cycle for pe_sum to settle, then EMIT.
  - EMIT: res_valid=1, with res_data = (relu_q && pe_sum<0) ? 0 : pe_sum, captured on WAIT->EMIT and held stable. Leave EMIT on res_valid&&res_ready:
    - col<OUT_W-1: col++ and go to SLIDE.
    - else row<OUT_H-1: row++, col=0 and go to FILL.
    - else DONE.
  - SLIDE: read address row*IMG_W+col+K_W-1, col_load the next cycle (2 cycles), then CLR.
  - DONE: done=1 for 1 cycle, then IDLE.
- start while busy is ignored.
- abort in any state: next state IDLE, all strobes 0, res_valid dropped, no done pulse. A pending result is lost.
- Exactly one of mem_re, col_load, pe_clear, pe_en is high in any cycle, except FILL, where mem_re and col_load overlap.

## Timing
- Reset values: state IDLE; busy, done, mem_re, col_load, pe_clear, pe_en, w_shift and res_valid all 0; mem_addr, col_data, res_data, out_row and out_col all 0.
- Per output with res_ready=1: CLR+MAC+WAIT+EMIT = K_W+3 cycles (6).
- Per row: FILL (K_W+1) + OUT_W outputs + (OUT_W-1) SLIDE×2 = 4+78+24 = 106 cycles.
- Full pass with defaults and res_ready held 1: start sampled at edge 0; done high in cycle 1485.
- Backpressure stretches EMIT only; no other state stalls.
- out_row and out_col are valid with res_valid and identify the emitted result.

## Configuration
- NPU_SCHED_PERF_EN defined: add outputs perf_cyc[31:0], counting busy cycles, and perf_stall[31:0], counting EMIT cycles with res_ready=0.
  - Both clear on start and on rst.
  - Both saturate at 2^32-1.
  - Both hold their value in IDLE.
- NPU_SCHED_PERF_EN undefined: both ports exist and are tied to 0, with no counter logic.

## Test plan
- Reset mid-MAC (rst pulsed during row 3): all outputs return to reset values asynchronously; a new start performs a full pass from row 0.
- All-ones image, all-ones weights, relu_en=0, res_ready=1: 182 results, each 9. done in cycle 1485. mem_addr sequence of row 0: 0,1,2,3,…,14.
- Negative weights giving pe_sum=-5: relu_en=1 → res_data=0; relu_en=0 → res_data=0xFFFFFB.
- res_ready low for 7 cycles on the 2nd result: res_valid and res_data stay stable; completion delayed by exactly 7; with perf enabled, perf_stall=7.
- abort asserted in SLIDE of row 2: next cycle IDLE, busy=0, no done pulse, no further mem_re.
- start asserted while busy: ignored, and the pass result count is still 182.
